// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory arbiter and its round-robin picker.
package mem_arb_pkg;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// modulo N, wins. Returns a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);
  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the byte-wide accelerator memory plus dump sequencing.
// Optional burst locking is compiled in with `define MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  input  logic                           dump_req,
  output logic                           dump_done,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_din,
  input  logic [DATA_WIDTH-1:0]          mem_dout,
  output logic                           mem_dump
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;
  logic                 grant_en;
  logic                 gnt_any;
  logic                 hold;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // A locked requester keeps the pointer on itself so it wins again next cycle.
`ifdef MEM_ARB_LOCK_EN
  assign hold = req_valid[arb_idx] & req_lock[arb_idx];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign hold        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (dump_req) state_d = DUMP;
      DUMP:    state_d = DONE;
      DONE:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Grants are gated by reset so nothing reaches memory while rst is high.
  always_comb begin
    grant_en  = !rst && (state_q == ARB) && !dump_req;
    req_ready = grant_en ? arb_gnt : '0;
    gnt_any   = grant_en && arb_vld;
    mem_we    = gnt_any && req_we[arb_idx];
    mem_addr  = gnt_any ? req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_din   = gnt_any ? req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    mem_dump  = !rst && (state_q == DUMP);
    dump_done = !rst && (state_q == DONE);
    rsp_valid = rsp_valid_q;
    rsp_rdata = mem_dout;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = req_ready;
    if (gnt_any) begin
      if (hold)                              rr_ptr_d = arb_idx;
      else if (arb_idx == IW'(NUM_REQ - 1))  rr_ptr_d = '0;
      else                                   rr_ptr_d = arb_idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered read-before-write memory.
module tb_mem_arbiter;
  localparam int NR = 3;
  localparam int AW = 24;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, mem_din, mem_dout;
  logic [AW-1:0]     mem_addr;
  logic              dump_req, dump_done, mem_we, mem_dump;

  int errs   = 0;
  int checks = 0;

  mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lock(req_lock), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .dump_req(dump_req), .dump_done(dump_done), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_dump(mem_dump)
  );

  always #5 clk = ~clk;

  // Unwritten bytes read back as addr^0x2C, so 0x10 initially holds 0x3C.
  logic [7:0] mem [256];
  logic       wr  [256];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) wr[a] <= 1'b0;
      mem_dout <= '0;
    end else begin
      mem_dout <= wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (mem_addr[7:0] ^ 8'h2C);
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_din;
        wr[mem_addr[7:0]]  <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    dump_req  = 1'b0;
    rst       = 1'b1;
    next_cyc();
    rst       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; dump_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 3'b111;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_dump", 32'(mem_dump), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_dump_done", 32'(dump_done), 32'h0);
    next_cyc();
    rst = 1'b0; req_valid = '0;

    // T1: write 0xA5 then read it back
    set_req(0, 1'b1, 24'h000010, 8'hA5);
    #1;
    chk("t1_wr_ready", 32'(req_ready), 32'h1);
    chk("t1_wr_we", 32'(mem_we), 32'h1);
    chk("t1_wr_addr", 32'(mem_addr), 32'h10);
    chk("t1_wr_din", 32'(mem_din), 32'hA5);
    next_cyc();
    set_req(0, 1'b0, 24'h000010, 8'h00);
    #1;
    chk("t1_wr_rsp", 32'(rsp_valid), 32'h1);
    chk("t1_wr_oldbyte", 32'(rsp_rdata), 32'h3C);
    chk("t1_rd_ready", 32'(req_ready), 32'h1);
    chk("t1_rd_we", 32'(mem_we), 32'h0);
    next_cyc();
    req_valid = '0;
    #1;
    chk("t1_rd_rsp", 32'(rsp_valid), 32'h1);
    chk("t1_rd_data", 32'(rsp_rdata), 32'hA5);
    chk("t1_idle_ready", 32'(req_ready), 32'h0);

    // T2: all three valid, round-robin 0,1,2,0,1,2
    do_reset();
    req_valid = 3'b111; req_we = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t2_grant", 32'(req_ready), 32'(1 << (k % 3)));
      if (k > 0) chk("t2_rsp", 32'(rsp_valid), 32'(1 << ((k - 1) % 3)));
      next_cyc();
    end
    req_valid = '0;
    #1;
    chk("t2_last_rsp", 32'(rsp_valid), 32'h4);
    chk("t2_idle_ready", 32'(req_ready), 32'h0);

    // T3: dump pre-empts req1
    set_req(1, 1'b0, 24'h000020, 8'h00);
    dump_req = 1'b1;
    #1;
    chk("t3_arb_ready", 32'(req_ready), 32'h0);
    chk("t3_arb_dump", 32'(mem_dump), 32'h0);
    next_cyc();
    dump_req = 1'b0;
    #1;
    chk("t3_dump_ready", 32'(req_ready), 32'h0);
    chk("t3_dump_pulse", 32'(mem_dump), 32'h1);
    chk("t3_dump_done0", 32'(dump_done), 32'h0);
    next_cyc();
    #1;
    chk("t3_done_pulse", 32'(dump_done), 32'h1);
    chk("t3_done_dump", 32'(mem_dump), 32'h0);
    chk("t3_done_ready", 32'(req_ready), 32'h0);
    next_cyc();
    #1;
    chk("t3_req1_grant", 32'(req_ready), 32'h2);
    chk("t3_done_clear", 32'(dump_done), 32'h0);
    next_cyc();
    req_valid = '0;

    // T4: reset during a read and a pending dump
    set_req(0, 1'b0, 24'h000010, 8'h00);
    #1;
    chk("t4_rd_ready", 32'(req_ready), 32'h1);
    next_cyc();
    rst = 1'b1; dump_req = 1'b1;
    #1;
    chk("t4_rst_rsp", 32'(rsp_valid), 32'h0);
    chk("t4_rst_dump", 32'(mem_dump), 32'h0);
    chk("t4_rst_ready", 32'(req_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      next_cyc();
      chk("t4_hold_dump", 32'(mem_dump), 32'h0);
      chk("t4_hold_done", 32'(dump_done), 32'h0);
      chk("t4_hold_rsp", 32'(rsp_valid), 32'h0);
    end
    rst = 1'b0; dump_req = 1'b0; req_valid = 3'b111;
    #1;
    chk("t4_ptr_zero", 32'(req_ready), 32'h1);
    next_cyc();
    req_valid = '0;
    #1;
    chk("t4_post_dump", 32'(mem_dump), 32'h0);
    chk("t4_post_done", 32'(dump_done), 32'h0);
    chk("t4_post_rsp", 32'(rsp_valid), 32'h1);

    // T5: only req2 for 4 cycles, pointer wraps to 0
    do_reset();
    req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_grant2", 32'(req_ready), 32'h4);
      if (k > 0) chk("t5_rsp2", 32'(rsp_valid), 32'h4);
      next_cyc();
    end
    req_valid = 3'b111;
    #1;
    chk("t5_wrap", 32'(req_ready), 32'h1);
    next_cyc();
    req_valid = '0;

`ifdef MEM_ARB_LOCK_EN
    // T6: req0 locked burst, req1 follows once lock drops
    do_reset();
    req_valid = 3'b011; req_lock = 3'b001;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_lock = '0;
      #1;
      chk("t6_lock_grant0", 32'(req_ready), 32'h1);
      next_cyc();
    end
    #1;
    chk("t6_grant1", 32'(req_ready), 32'h2);
    req_valid = '0; req_lock = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
